demux_seq_driver: RTL and testbench

- Registered sequencer that drives the data input and select bus of a 1-to-2^SEL_W demux tree.
- Accepts single-target write requests through a valid/ready port and buffers them in a small FIFO.
- Also runs a full-range scan that walks the select value through every demux output.
- Guarantees break-before-make: the demux data input is held at 0 whenever the select value changes, so no glitch reaches a neighbouring output.

---
 rtl/demux_seq_driver.sv | 186 ++++++++++++++++++
 tb/tb_demux_seq_driver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_seq_driver.sv
// Break-before-make sequencer driving a 1-to-2^SEL_W demux tree.
// Optional sticky overflow flag: define DEMUX_SEQ_OVF_FLAG_EN.
module demux_seq_driver #(
  parameter int SEL_W       = 9,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SEL_W-1:0] req_sel,
  input  logic             req_data,
  input  logic             scan_start,
  input  logic             scan_data,
  output logic             dmx_in,
  output logic [SEL_W-1:0] dmx_sel,
  output logic             busy,
  output logic             done
`ifdef DEMUX_SEQ_OVF_FLAG_EN
  ,
  output logic             ovf_err
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [HW-1:0]    HOLD_INIT = HW'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_MAX   = {SEL_W{1'b1}};
  localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             data;
  } ent_t;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    GAP,
    SCAN_DRIVE,
    SCAN_GAP
  } state_t;

  ent_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  state_t           state_q;
  logic [HW-1:0]    hold_q;
  logic             scan_q;
  logic             dmx_in_q;
  logic [SEL_W-1:0] dmx_sel_q;
  logic             done_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  ent_t head;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign push  = req_valid && !full;
  // Scan start wins over a pending request in IDLE.
  assign pop   = (state_q == IDLE) && !scan_start && !empty;
  assign head  = mem_q[rd_ptr_q];

  assign req_ready = !full;
  assign dmx_in    = dmx_in_q;
  assign dmx_sel   = dmx_sel_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{sel: req_sel, data: req_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      scan_q    <= 1'b0;
      dmx_in_q  <= 1'b0;
      dmx_sel_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          dmx_in_q <= 1'b0;
          if (scan_start) begin
            state_q   <= SCAN_DRIVE;
            scan_q    <= scan_data;
            dmx_sel_q <= '0;
            dmx_in_q  <= scan_data;
            hold_q    <= HOLD_INIT;
          end else if (pop) begin
            state_q   <= DRIVE;
            dmx_sel_q <= head.sel;
            dmx_in_q  <= head.data;
            hold_q    <= HOLD_INIT;
          end
        end
        DRIVE: begin
          if (hold_q == '0) begin
            state_q  <= GAP;
            dmx_in_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
        end
        SCAN_DRIVE: begin
          if (hold_q == '0) begin
            state_q  <= SCAN_GAP;
            dmx_in_q <= 1'b0;
            done_q   <= (dmx_sel_q == SEL_MAX);
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        SCAN_GAP: begin
          if (dmx_sel_q == SEL_MAX) begin
            state_q <= IDLE;
          end else begin
            state_q   <= SCAN_DRIVE;
            dmx_sel_q <= dmx_sel_q + SEL_W'(1);
            dmx_in_q  <= scan_q;
            hold_q    <= HOLD_INIT;
          end
        end
        default: begin
          state_q  <= IDLE;
          dmx_in_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_SEQ_OVF_FLAG_EN
  logic ovf_q;

  assign ovf_err = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (req_valid && full) begin
      ovf_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_seq_driver.sv
// Directed bench for demux_seq_driver: reset, requests,
// back-pressure, full scans and select-change monitor.
module tb_demux_seq_driver;

  localparam int SW = 9;
  localparam int HC = 2;
  localparam int SCAN_LEN = (1 << SW) * (HC + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [SW-1:0] req_sel;
  logic          req_data;
  logic          scan_start;
  logic          scan_data;
  logic          dmx_in;
  logic [SW-1:0] dmx_sel;
  logic          busy;
  logic          done;
`ifdef DEMUX_SEQ_OVF_FLAG_EN
  logic          ovf_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_seq_driver #(
    .SEL_W      (SW),
    .FIFO_DEPTH (4),
    .HOLD_CYCLES(HC)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .scan_start(scan_start),
    .scan_data (scan_data),
    .dmx_in    (dmx_in),
    .dmx_sel   (dmx_sel),
    .busy      (busy),
    .done      (done)
`ifdef DEMUX_SEQ_OVF_FLAG_EN
    ,
    .ovf_err   (ovf_err)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle with the entry at the FIFO head.
  task automatic drive_chk(input logic [SW-1:0] s, input logic d);
    step;
    chk("req_load", 32'({dmx_sel, dmx_in, busy, done}),
        32'({s, d, 1'b1, 1'b0}));
    step;
    chk("req_hold", 32'({dmx_sel, dmx_in, busy, done}),
        32'({s, d, 1'b1, 1'b0}));
    step;
    chk("req_gap", 32'({dmx_sel, dmx_in, busy, done}),
        32'({s, 1'b0, 1'b1, 1'b1}));
    step;
    chk("req_idle", 32'({dmx_sel, dmx_in, busy, done}),
        32'({s, 1'b0, 1'b0, 1'b0}));
  endtask

  // Select may only move while the output being left is released.
  logic          rst_seen;
  logic [SW-1:0] p_sel;
  logic          p_in;

  always @(posedge clk) rst_seen <= rst_n;

  always @(negedge clk) begin
    if (rst_seen === 1'b1 && dmx_sel !== p_sel)
      chk("glitch", 32'(p_in), 32'd0);
    p_sel = dmx_sel;
    p_in  = dmx_in;
  end

  logic [SW-1:0] bp_sel [6];
  logic          bp_dat [6];
  logic [SW-1:0] es;
  logic          ei;
  int            k;

  initial begin
    bp_sel = '{9'h003, 9'h1FF, 9'h100, 9'h0AA, 9'h011, 9'h022};
    bp_dat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_sel    = '0;
    req_data   = 1'b0;
    scan_start = 1'b0;
    scan_data  = 1'b0;
    repeat (2) step;
    chk("reset", 32'({dmx_in, dmx_sel, busy, done, req_ready}),
        32'({1'b0, 9'd0, 1'b0, 1'b0, 1'b1}));
    rst_n = 1'b1;
    step;
    chk("idle", 32'({dmx_in, dmx_sel, busy, done, req_ready}),
        32'({1'b0, 9'd0, 1'b0, 1'b0, 1'b1}));
`ifdef DEMUX_SEQ_OVF_FLAG_EN
    chk("ovf_reset", 32'(ovf_err), 32'd0);
`endif

    // single request
    req_valid = 1'b1;
    req_sel   = 9'h1A5;
    req_data  = 1'b1;
    step;
    req_valid = 1'b0;
    chk("push_idle", 32'({busy, req_ready}), 32'b01);
    drive_chk(9'h1A5, 1'b1);

    // reset in the middle of DRIVE
    req_valid = 1'b1;
    req_sel   = 9'h055;
    step;
    req_valid = 1'b0;
    step;
    chk("mid_drive", 32'({dmx_sel, busy, dmx_in}),
        32'({9'h055, 1'b1, 1'b1}));
    rst_n = 1'b0;
    step;
    chk("rst_mid", 32'({dmx_in, dmx_sel, busy, done, req_ready}),
        32'({1'b0, 9'd0, 1'b0, 1'b0, 1'b1}));
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk("no_done", 32'({busy, done, dmx_in}), 32'd0);
    end

    // scan and request together; scan first, later start ignored
    scan_start = 1'b1;
    scan_data  = 1'b1;
    req_valid  = 1'b1;
    req_sel    = 9'h0F0;
    req_data   = 1'b1;
    step;
    scan_start = 1'b0;
    scan_data  = 1'b0;
    req_valid  = 1'b0;
    for (k = 0; k < SCAN_LEN; k++) begin
      es = SW'(k / (HC + 1));
      ei = (k % (HC + 1)) < HC;
      chk("scan", 32'({dmx_sel, dmx_in, done, busy}),
          32'({es, ei, (k == SCAN_LEN - 1), 1'b1}));
      if (k == 10) scan_start = 1'b1;
      if (k == 11) scan_start = 1'b0;
      if (k < SCAN_LEN - 1) step;
    end
    step;
    chk("scan_end", 32'({busy, dmx_in, done, dmx_sel}),
        32'({1'b0, 1'b0, 1'b0, 9'h1FF}));
    drive_chk(9'h0F0, 1'b1);

    // back-pressure while a scan stalls the FIFO
    scan_start = 1'b1;
    scan_data  = 1'b0;
    step;
    scan_start = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1;
      req_sel   = bp_sel[i];
      req_data  = bp_dat[i];
      chk("bp_ready", 32'(req_ready), 32'(i < 4));
      step;
      k++;
    end
    req_valid = 1'b0;
    chk("full_ready", 32'({req_ready, busy}), 32'b01);
`ifdef DEMUX_SEQ_OVF_FLAG_EN
    chk("ovf_set", 32'(ovf_err), 32'd1);
`endif
    while (done !== 1'b1 && k < SCAN_LEN + 10) begin
      step;
      k++;
    end
    chk("scan_len", 32'(k), 32'(SCAN_LEN - 1));
    chk("scan_done", 32'({done, dmx_sel}), 32'({1'b1, 9'h1FF}));
    step;
    chk("bp_idle", 32'({busy, dmx_in}), 32'd0);
    for (int i = 0; i < 4; i++) drive_chk(bp_sel[i], bp_dat[i]);
    repeat (3) begin
      step;
      chk("drained", 32'({busy, req_ready, dmx_in}), 32'b010);
    end
`ifdef DEMUX_SEQ_OVF_FLAG_EN
    chk("ovf_sticky", 32'(ovf_err), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
